// File: rtl/mux_nto1_rr.sv
// N-to-1 data multiplexer with fixed-select or round-robin arbitration,
// feeding a one-entry registered output stage with valid/ready handshaking.
module mux_nto1_rr #(
    parameter int WIDTH = 4,
    parameter int NCH   = 4,
    parameter int SELW  = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [NCH*WIDTH-1:0]   inp,
    input  logic [NCH-1:0]         inp_valid,
    output logic [NCH-1:0]         inp_ready,
    input  logic [SELW-1:0]        sel,
    input  logic                   mode,
    output logic [WIDTH-1:0]       out,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [SELW-1:0]        out_ch
);

    logic [WIDTH-1:0] r_out;
    logic [SELW-1:0]  r_out_ch;
    logic [SELW-1:0]  r_ptr;
    logic             r_out_valid;

    logic             w_load_en;
    logic             w_gnt_vld;
    logic [SELW-1:0]  w_gnt;
    logic [WIDTH-1:0] w_gnt_data;
    logic [SELW-1:0]  w_ptr_nxt;
    logic             w_xfer;

    assign w_load_en = !r_out_valid || out_ready;
    assign w_xfer    = w_load_en && w_gnt_vld;

    // Round-robin picks the valid channel at the smallest rotated distance from r_ptr.
    always_comb begin
        int unsigned w_best_d;
        int unsigned w_d;
        int unsigned w_ptr_i;
        w_gnt_vld  = 1'b0;
        w_gnt      = '0;
        w_gnt_data = '0;
        w_best_d   = NCH;
        w_d        = 0;
        w_ptr_i    = 32'(r_ptr);
        for (int unsigned i = 0; i < NCH; i++) begin
            if (mode) begin
                w_d = (i >= w_ptr_i) ? (i - w_ptr_i) : (i + NCH - w_ptr_i);
                if (inp_valid[i] && (w_d < w_best_d)) begin
                    w_best_d   = w_d;
                    w_gnt_vld  = 1'b1;
                    w_gnt      = SELW'(i);
                    w_gnt_data = inp[i*WIDTH +: WIDTH];
                end
            end else if (inp_valid[i] && (32'(sel) == i)) begin
                w_gnt_vld  = 1'b1;
                w_gnt      = SELW'(i);
                w_gnt_data = inp[i*WIDTH +: WIDTH];
            end
        end
    end

    assign w_ptr_nxt = (w_gnt == SELW'(NCH - 1)) ? '0 : (w_gnt + SELW'(1));
    assign inp_ready = (w_xfer && !rst) ? (NCH'(1) << w_gnt) : '0;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_out       <= '0;
            r_out_ch    <= '0;
            r_out_valid <= 1'b0;
            r_ptr       <= '0;
        end else begin
            if (w_load_en) begin
                if (w_gnt_vld) begin
                    r_out       <= w_gnt_data;
                    r_out_ch    <= w_gnt;
                    r_out_valid <= 1'b1;
                end else begin
                    r_out_valid <= 1'b0;
                end
            end
            if (mode && w_xfer) begin
                r_ptr <= w_ptr_nxt;
            end
        end
    end

    assign out       = r_out;
    assign out_ch    = r_out_ch;
    assign out_valid = r_out_valid;

endmodule

// File: tb/tb_mux_nto1_rr.sv
// Bench for mux_nto1_rr: a 4-channel and a 3-channel instance share stimulus and
// are compared every cycle against a queue-free behavioural model of the arbiter.
module tb_mux_nto1_rr;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] inp = '0;
    logic [3:0]  vld = '0;
    logic [1:0]  sel = '0;
    logic        mode = 1'b0;
    logic        ordy = 1'b0;

    logic [3:0]  rdy4;
    logic [3:0]  out4;
    logic        ov4;
    logic [1:0]  och4;
    logic [2:0]  rdy3;
    logic [3:0]  out3;
    logic        ov3;
    logic [1:0]  och3;

    int checks = 0;
    int errors = 0;

    // Model state, index 0 = 4-channel instance, index 1 = 3-channel instance
    logic [3:0] m_out [2];
    int         m_ch  [2];
    bit         m_vld [2];
    int         m_ptr [2];

    always #10 clk = ~clk;

    mux_nto1_rr #(.WIDTH(4), .NCH(4), .SELW(2)) dut4 (
        .clk(clk), .rst(rst), .inp(inp), .inp_valid(vld), .inp_ready(rdy4),
        .sel(sel), .mode(mode), .out(out4), .out_valid(ov4), .out_ready(ordy),
        .out_ch(och4)
    );

    mux_nto1_rr #(.WIDTH(4), .NCH(3), .SELW(2)) dut3 (
        .clk(clk), .rst(rst), .inp(inp[11:0]), .inp_valid(vld[2:0]), .inp_ready(rdy3),
        .sel(sel), .mode(mode), .out(out3), .out_valid(ov3), .out_ready(ordy),
        .out_ch(och3)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, req, $time);
        end
    endtask

    function automatic int nch_of(input int j);
        return (j == 0) ? 4 : 3;
    endfunction

    // Grant decision straight from the rules: fixed select, or first valid
    // channel walking forward from the pointer with wraparound.
    function automatic int mgrant(input int j);
        int n;
        int c;
        n = nch_of(j);
        if (!mode) begin
            if (int'(sel) < n && vld[sel]) return int'(sel);
            return -1;
        end
        for (int k = 0; k < n; k++) begin
            c = (m_ptr[j] + k) % n;
            if (vld[c]) return c;
        end
        return -1;
    endfunction

    function automatic logic [3:0] exp_ready(input int j);
        int g;
        g = mgrant(j);
        if (rst) return 4'b0;
        if ((!m_vld[j] || ordy) && g >= 0) return 4'(1 << g);
        return 4'b0;
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int j = 0; j < 2; j++) begin
                m_out[j] = '0; m_ch[j] = 0; m_vld[j] = 1'b0; m_ptr[j] = 0;
            end
        end else begin
            for (int j = 0; j < 2; j++) begin
                int g;
                g = mgrant(j);
                if (!m_vld[j] || ordy) begin
                    if (g >= 0) begin
                        m_out[j] = inp[g*4 +: 4];
                        m_ch[j]  = g;
                        m_vld[j] = 1'b1;
                        if (mode) m_ptr[j] = (g + 1) % nch_of(j);
                    end else begin
                        m_vld[j] = 1'b0;
                    end
                end
            end
        end
    end

    always @(negedge clk) begin
        chk("rdy4", 32'(rdy4), 32'(exp_ready(0)));
        chk("ov4",  32'(ov4),  32'(m_vld[0]));
        chk("out4", 32'(out4), 32'(m_out[0]));
        chk("och4", 32'(och4), 32'(m_ch[0]));
        chk("rdy3", 32'(rdy3), 32'(exp_ready(1)));
        chk("ov3",  32'(ov3),  32'(m_vld[1]));
        chk("out3", 32'(out3), 32'(m_out[1]));
        chk("och3", 32'(och3), 32'(m_ch[1]));
    end

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [3:0] seq_out [5];
        logic [1:0] seq_ch  [5];
        seq_out = '{4'h1, 4'h2, 4'h3, 4'h4, 4'h1};
        seq_ch  = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};

        // Reset state
        @(negedge clk);
        chk("rst_out",   32'(out4), 32'h0);
        chk("rst_ov",    32'(ov4),  32'h0);
        chk("rst_och",   32'(och4), 32'h0);
        chk("rst_ready", 32'(rdy4), 32'h0);

        // Fixed mode, sel=2
        cycle();
        rst = 1'b0; mode = 1'b0; sel = 2'd2; vld = 4'b0100; inp = 16'h0A00; ordy = 1'b1;
        @(negedge clk);
        chk("fix_ready", 32'(rdy4), 32'h4);
        cycle();
        mode = 1'b1; vld = 4'b1111; inp = 16'h4321;
        @(negedge clk);
        chk("fix_out", 32'(out4), 32'hA);
        chk("fix_och", 32'(och4), 32'h2);
        chk("fix_ov",  32'(ov4),  32'h1);

        // Round-robin across all four channels
        for (int k = 0; k < 5; k++) begin
            cycle();
            if (k == 4) vld = 4'b0100;
            @(negedge clk);
            chk("rr_out", 32'(out4), 32'(seq_out[k]));
            chk("rr_och", 32'(och4), 32'(seq_ch[k]));
        end

        // Pointer wraps from 3 past the gap to channel 0, then channel 1
        cycle();
        vld = 4'b0011;
        @(negedge clk);
        chk("wrap_pre_och", 32'(och4), 32'h2);
        cycle();
        @(negedge clk);
        chk("wrap_och0", 32'(och4), 32'h0);
        chk("wrap_out0", 32'(out4), 32'h1);
        cycle();
        ordy = 1'b0; vld = 4'b1111;
        @(negedge clk);
        chk("wrap_och1",  32'(och4), 32'h1);
        chk("bp_ready",   32'(rdy4), 32'h0);

        // Backpressure for three cycles, then release with same-edge reload
        for (int k = 0; k < 3; k++) begin
            cycle();
            if (k == 2) ordy = 1'b1;
            @(negedge clk);
            chk("bp_out", 32'(out4), 32'h2);
            chk("bp_och", 32'(och4), 32'h1);
            chk("bp_ov",  32'(ov4),  32'h1);
            if (k < 2) chk("bp_ready_hold", 32'(rdy4), 32'h0);
            else       chk("bp_ready_rel",  32'(rdy4), 32'h4);
        end
        cycle();
        mode = 1'b0; sel = 2'd3;
        @(negedge clk);
        chk("bp_reload_out", 32'(out4), 32'h3);
        chk("bp_reload_och", 32'(och4), 32'h2);

        // Out-of-range select on the 3-channel instance
        chk("oor_ready3", 32'(rdy3), 32'h0);
        chk("oor_pend3",  32'(ov3),  32'h1);
        cycle();
        mode = 1'b1; ordy = 1'b0;
        @(negedge clk);
        chk("oor_drop3", 32'(ov3), 32'h0);

        // Asynchronous reset pulse between edges
        cycle();
        chk("mid_pre_ov", 32'(ov4), 32'h1);
        #2 rst = 1'b1;
        #1;
        chk("mid_rst_ov",    32'(ov4),  32'h0);
        chk("mid_rst_out",   32'(out4), 32'h0);
        chk("mid_rst_ready", 32'(rdy4), 32'h0);
        #1 rst = 1'b0; ordy = 1'b1;
        cycle();
        @(negedge clk);
        chk("post_rst_och", 32'(och4), 32'h0);
        chk("post_rst_out", 32'(out4), 32'h1);

        // Randomized traffic with occasional asynchronous resets
        for (int n = 0; n < 3000; n++) begin
            cycle();
            inp  = 16'($urandom);
            vld  = 4'($urandom);
            sel  = 2'($urandom);
            mode = ($urandom_range(0, 7) != 0) ? ~mode : mode;
            ordy = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 60) == 0) begin
                #2 rst = 1'b1;
                #2 rst = 1'b0;
            end
        end

        @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mux_nto1_rr.md
MUX_NTO1_RR -- requirements
Module: mux_nto1_rr

Interface
REQ-001 Parameter WIDTH, default 4: data bits per channel; the block SHALL support any WIDTH >= 1.
REQ-002 Parameter NCH, default 4: number of input channels; the block SHALL support NCH from 2 to 16.
REQ-003 Parameter SELW, default 2: select width; the block SHALL require 2**SELW >= NCH.
REQ-004 clk  input  1  single clock; all state SHALL update on the rising edge only.
REQ-005 rst  input  1  reset, asynchronous and active-high.
REQ-006 inp  input  NCH*WIDTH  flattened channel data; channel i occupies bits [i*WIDTH +: WIDTH].
REQ-007 inp_valid  input  NCH  per-channel data-valid.
REQ-008 inp_ready  output  NCH  per-channel accept; combinational.
REQ-009 sel  input  SELW  channel select used in fixed mode.
REQ-010 mode  input  1  0 = fixed select, 1 = round-robin.
REQ-011 out  output  WIDTH  registered selected data.
REQ-012 out_valid  output  1  out holds an untransferred word.
REQ-013 out_ready  input  1  downstream accept.
REQ-014 out_ch  output  SELW  registered index of the channel that supplied out.

Function
REQ-015 Transfer definitions: an input transfer on channel i SHALL occur when inp_valid[i] & inp_ready[i]; an output transfer SHALL occur when out_valid & out_ready.
REQ-016 load_en SHALL equal (!out_valid | out_ready), giving a one-entry output register with full throughput.
REQ-017 Fixed mode (mode=0): the grant SHALL be channel sel when sel < NCH and inp_valid[sel]=1; otherwise there SHALL be no grant.
REQ-018 With sel >= NCH, no channel SHALL be granted, and inp_ready SHALL be all zero.
REQ-019 Round-robin mode (mode=1): the grant SHALL be the first channel with inp_valid=1, searching ptr, ptr+1, ..., NCH-1, 0, ..., ptr-1.
REQ-020 inp_ready[i] SHALL be 1 only when load_en=1 and channel i is granted; at most one bit SHALL be set in any cycle.
REQ-021 Inputs SHALL NOT depend on inp_ready before asserting inp_valid, so no combinational loop exists.
REQ-022 When a grant and load_en coincide on a clock edge, out <= granted data, out_ch <= grant and out_valid <= 1 (latency 1 cycle from input transfer to out_valid).
REQ-023 When load_en=1 and there is no grant, out_valid SHALL go to 0 on the edge, and out/out_ch SHALL hold their values.
REQ-024 When load_en=0 (out_valid=1, out_ready=0), out, out_ch and out_valid SHALL hold, and inp_ready SHALL be 0 (backpressure).
REQ-025 Pointer update: ptr (SELW bits, internal) SHALL become (grant+1), wrapping NCH-1 -> 0, on every input transfer in mode 1; ptr SHALL hold in mode 0 and when there is no transfer.
REQ-026 Simultaneous output and input transfer in the same cycle SHALL replace the word with no bubble.
REQ-027 A mode change SHALL take effect on the next grant decision; the word already in out SHALL be unaffected.

Reset
REQ-028 While rst=1: out=0, out_ch=0, out_valid=0 and ptr=0, asynchronously, regardless of clk.
REQ-029 While rst=1, inp_ready SHALL be 0.
REQ-030 Reset asserted mid-stream SHALL discard the held word; the first grant after release SHALL search from channel 0.

Verification
REQ-031 Reset release, mode=0, sel=2, inp_valid=4'b0100, ch2=4'hA, out_ready=1 -> inp_ready=4'b0100; next cycle out=4'hA, out_ch=2, out_valid=1.
REQ-032 mode=1, inp_valid=4'b1111, out_ready=1 held, channel data 1,2,3,4 -> out sequence 1,2,3,4,1 on consecutive cycles; out_ch = 0,1,2,3,0.
REQ-033 mode=1, ptr=3, inp_valid=4'b0011 -> channel 0 granted; ptr becomes 1; next grant is channel 1.
REQ-034 out_valid=1, out_ready=0 for 3 cycles with inputs valid -> out stable, inp_ready=0; out_ready=1 -> transfer plus new load on the same edge.
REQ-035 NCH=3, SELW=2, mode=0, sel=3 -> inp_ready=0; out_valid drops after the pending word transfers.
REQ-036 rst pulsed between clock edges with out_valid=1 -> out_valid=0 and out=0 immediately; after release, round-robin starts at channel 0.
